// File: rtl/pointer_chain_memory.sv
// rtl/pointer_chain_memory.sv - on-chip word memory responder that self-fills with a pointer chain
// Serves single-port reads/writes once the fill completes; REFILL restarts the fill.
module pointer_chain_memory #(
  parameter int W_A         = 24,
  parameter int W_D         = 32,
  parameter int DEPTH_LOG   = 10,
  parameter int INIT_STRIDE = 1,
  parameter int BYTE_ENABLE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [W_A-1:0]   ADDR,
  input  logic [W_D-1:0]   D,
  input  logic             WE,
  input  logic             RE,
  input  logic [W_D/8-1:0] BE,
  output logic [W_D-1:0]   Q,
  input  logic             REFILL,
  output logic             READY,
  output logic [31:0]      ACC_CNT
);

  localparam int NB    = W_D / 8;
  localparam int AL    = $clog2(NB);
  localparam int DEPTH = 2 ** DEPTH_LOG;

  localparam logic [DEPTH_LOG-1:0] STRIDE   = DEPTH_LOG'(INIT_STRIDE);
  localparam logic [DEPTH_LOG-1:0] LAST_IDX = DEPTH_LOG'(DEPTH - 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [DEPTH_LOG-1:0] idx_q;
  logic [DEPTH_LOG-1:0] idx_d;
  logic [W_D-1:0]       mem [DEPTH];
  logic [DEPTH_LOG-1:0] word;
  logic [W_D-1:0]       fill_val;
  logic [W_D-1:0]       wr_mask;
  logic                 wr_en;
  logic                 rd_en;
  logic                 unused_bits;

  // Byte offset and bits above the word index are dropped, so addresses wrap.
  assign word        = ADDR[DEPTH_LOG+AL-1:AL];
  assign unused_bits = ^{ADDR, BE};

  assign READY = (state_q == S_RUN);
  assign wr_en = READY & WE;
  assign rd_en = READY & RE;

  // Truncating the sum to DEPTH_LOG bits gives the modulo-DEPTH wrap.
  assign fill_val = {{(W_D-DEPTH_LOG){1'b0}}, idx_q + STRIDE};

  always_comb begin
    wr_mask = '0;
    for (int k = 0; k < NB; k++) begin
      wr_mask[8*k +: 8] = ((BYTE_ENABLE == 0) || BE[k]) ? 8'hFF : 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_FILL: begin
        idx_d = idx_q + 1'b1;
        if (REFILL) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (REFILL) begin
          state_d = S_FILL;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_FILL;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_FILL;
      idx_q   <= '0;
      Q       <= '0;
      ACC_CNT <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      // Sampled before this edge's write lands, giving read-before-write.
      if (rd_en) begin
        Q <= mem[word];
      end
      if ((wr_en | rd_en) && (ACC_CNT != 32'hFFFF_FFFF)) begin
        ACC_CNT <= ACC_CNT + 32'd1;
      end
    end
  end

  // Array has no reset; contents are rebuilt by the fill after every reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_FILL) begin
      mem[idx_q] <= fill_val;
    end else if (WE) begin
      mem[word] <= (mem[word] & ~wr_mask) | (D & wr_mask);
    end
  end

endmodule
